iir_multi: RTL

Parametrised, multi-channel fixed-point IIR filter for the FM radio datapath. It generalises the single-channel deemphasis IIR in width, tap count and channel count, and adds an optional saturating output stage. It sits between a first-word-fall-through input FIFO and an output FIFO. Samples arrive channel-interleaved (e.g. L/R audio) and each channel keeps independent filter history.

---
 rtl/iir_pkg.sv | 38 +++
 rtl/iir_tap_mac.sv | 68 ++++++
 rtl/iir_multi.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/iir_pkg.sv
// iir_pkg: shared types, defaults and arithmetic helpers for the iir_multi
// filter slice.
//   iir_state_e   - controller states (S_READ, S_MAC, S_WRITE)
//   DEEMPH_BITS   - default coefficient fractional bits
//   DEEMPH_X/Y    - default deemphasis coefficient sets (index 0 = tap 0)
//   deq()         - dequantise a product: divide by 2^shift, truncating
//                   toward zero to match the C reference model
package iir_pkg;

  typedef enum logic [1:0] {
    S_READ  = 2'd0,
    S_MAC   = 2'd1,
    S_WRITE = 2'd2
  } iir_state_e;

  localparam int DEEMPH_BITS = 10;

  // Packed arrays: element [0] is the rightmost item of the concatenation.
  localparam logic [1:0][31:0] DEEMPH_X = {32'd178, 32'd178};
  localparam logic [1:0][31:0] DEEMPH_Y = {32'(-666), 32'd0};

  // Working width of deq(); callers sign-extend their product into it and
  // truncate the quotient back to their accumulator width.
  localparam int DEQ_W = 128;

  // An arithmetic shift alone rounds toward minus infinity; biasing negative
  // values by 2^shift-1 first turns that into truncation toward zero.
  function automatic logic signed [DEQ_W-1:0] deq(
    input logic signed [DEQ_W-1:0] p,
    input int                      shift
  );
    logic signed [DEQ_W-1:0] bias;
    bias = (DEQ_W'(1) << shift) - DEQ_W'(1);
    if (p < 0) return (p + bias) >>> shift;
    else       return p >>> shift;
  endfunction

endpackage

// File: rtl/iir_tap_mac.sv
// iir_tap_mac: one-tap-per-cycle multiply/dequantise/accumulate datapath.
//   clock, reset   - rising-edge clock, asynchronous active-low reset
//   clear_i        - zero the accumulator (start of a new sample)
//   en_i           - add this cycle's tap contribution
//   fb_en_i        - include the feedback term (low for tap 0)
//   b_i, x_i       - feed-forward coefficient and x history sample
//   a_i, y_i       - feedback coefficient and y history sample
//   result_o       - accumulator reduced to DATA_WIDTH
//   clip_o         - result was clipped (only when IIR_SAT_EN is defined)
// Macro IIR_SAT_EN selects saturating reduction; otherwise the result is the
// low DATA_WIDTH bits of the accumulator.
module iir_tap_mac
  import iir_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BITS       = DEEMPH_BITS,
  parameter int ACC_W      = 34
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clear_i,
  input  logic                         en_i,
  input  logic                         fb_en_i,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  input  logic signed [DATA_WIDTH-1:0] x_i,
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] y_i,
`ifdef IIR_SAT_EN
  output logic                         clip_o,
`endif
  output logic signed [DATA_WIDTH-1:0] result_o
);

  localparam int PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0]    prod_ff, prod_fb;
  logic signed [ACC_W-1:0] term_ff, term_fb;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  assign prod_ff = PW'(b_i) * PW'(x_i);
  assign prod_fb = PW'(a_i) * PW'(y_i);

  assign term_ff = ACC_W'(deq(DEQ_W'(prod_ff), BITS));
  assign term_fb = fb_en_i ? ACC_W'(deq(DEQ_W'(prod_fb), BITS)) : '0;

  always_comb begin
    acc_d = acc_q;
    if (clear_i)   acc_d = '0;
    else if (en_i) acc_d = acc_q + term_ff + term_fb;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) acc_q <= '0;
    else        acc_q <= acc_d;
  end

`ifdef IIR_SAT_EN
  // Out of range when the bits above the result's sign bit disagree with it.
  logic ovf;
  assign ovf      = acc_q[ACC_W-1:DATA_WIDTH-1] != {(ACC_W-DATA_WIDTH+1){acc_q[ACC_W-1]}};
  assign clip_o   = ovf;
  assign result_o = ovf ? {acc_q[ACC_W-1], {(DATA_WIDTH-1){~acc_q[ACC_W-1]}}}
                        : acc_q[DATA_WIDTH-1:0];
`else
  assign result_o = acc_q[DATA_WIDTH-1:0];
`endif

endmodule

// File: rtl/iir_multi.sv
// iir_multi: multi-channel fixed-point IIR filter between a first-word-fall-
// through input FIFO and an output FIFO. Channels arrive interleaved and each
// keeps its own x/y history.
//   clock, reset            - rising-edge clock, asynchronous active-low reset
//   x_in_rd_en/x_in_empty/x_in - input FIFO pop, empty flag and head word
//   y_out/y_out_wr_en/y_out_full - output sample, push strobe, full flag
//   ch_out                  - channel of y_out, qualified by y_out_wr_en
//   sat_seen                - sticky clip flag (only with IIR_SAT_EN)
// Macro IIR_SAT_EN: saturating output stage plus the sat_seen port.
module iir_multi
  import iir_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAPS       = 2,
  parameter int BITS       = DEEMPH_BITS,
  parameter int CHANNELS   = 2,
  parameter logic [TAPS-1:0][DATA_WIDTH-1:0] X_COEFFS = DEEMPH_X,
  parameter logic [TAPS-1:0][DATA_WIDTH-1:0] Y_COEFFS = DEEMPH_Y,
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  x_in_rd_en,
  input  logic                  x_in_empty,
  input  logic [DATA_WIDTH-1:0] x_in,
  output logic [DATA_WIDTH-1:0] y_out,
  output logic                  y_out_wr_en,
  input  logic                  y_out_full,
`ifdef IIR_SAT_EN
  output logic                  sat_seen,
`endif
  output logic [CH_W-1:0]       ch_out
);

  localparam int TAP_W = $clog2(TAPS);
  localparam int ACC_W = DATA_WIDTH + $clog2(2 * TAPS);
  // Tables are padded to a power of two so the pointers index them exactly.
  localparam int NCH   = 2 ** CH_W;
  localparam int NTAP  = 2 ** TAP_W;

  iir_state_e       state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [CH_W-1:0]  chan_q, chan_d;
  logic             rd_en, wr_en, mac_clear, mac_en;

  logic signed [DATA_WIDTH-1:0] x_hist_q [NCH][NTAP];
  logic signed [DATA_WIDTH-1:0] y_hist_q [NCH][NTAP];  // [0] unused: y[n] is the result
  logic signed [DATA_WIDTH-1:0] b_tab [NTAP];
  logic signed [DATA_WIDTH-1:0] a_tab [NTAP];
  logic signed [DATA_WIDTH-1:0] result;

  for (genvar gi = 0; gi < NTAP; gi++) begin : g_coef
    if (gi < TAPS) begin : g_used
      assign b_tab[gi] = X_COEFFS[gi];
      assign a_tab[gi] = Y_COEFFS[gi];
    end else begin : g_pad
      assign b_tab[gi] = '0;
      assign a_tab[gi] = '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    chan_d    = chan_q;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    mac_clear = 1'b0;
    mac_en    = 1'b0;
    case (state_q)
      S_READ: begin
        // reset gates the pop so no word is lost while the core is held.
        if (!x_in_empty && reset) begin
          rd_en     = 1'b1;
          mac_clear = 1'b1;
          tap_d     = '0;
          state_d   = S_MAC;
        end
      end
      S_MAC: begin
        mac_en = 1'b1;
        if (tap_q == TAP_W'(TAPS - 1)) begin
          tap_d   = '0;
          state_d = S_WRITE;
        end else begin
          tap_d = tap_q + TAP_W'(1);
        end
      end
      S_WRITE: begin
        if (!y_out_full) begin
          wr_en   = 1'b1;
          chan_d  = (chan_q == CH_W'(CHANNELS - 1)) ? '0 : chan_q + CH_W'(1);
          state_d = S_READ;
        end
      end
      default: state_d = S_READ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_READ;
      tap_q   <= '0;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      chan_q  <= chan_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NCH; c++) begin
        for (int t = 0; t < NTAP; t++) begin
          x_hist_q[c][t] <= '0;
          y_hist_q[c][t] <= '0;
        end
      end
    end else begin
      if (rd_en) begin
        x_hist_q[chan_q][0] <= x_in;
        for (int t = 1; t < TAPS; t++) x_hist_q[chan_q][t] <= x_hist_q[chan_q][t-1];
      end
      if (wr_en) begin
        y_hist_q[chan_q][1] <= result;
        for (int t = 2; t < TAPS; t++) y_hist_q[chan_q][t] <= y_hist_q[chan_q][t-1];
      end
    end
  end

`ifdef IIR_SAT_EN
  logic mac_clip;
  logic sat_seen_q;
`endif

  iir_tap_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .BITS       (BITS),
    .ACC_W      (ACC_W)
  ) u_mac (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (mac_clear),
    .en_i     (mac_en),
    .fb_en_i  (tap_q != '0),
    .b_i      (b_tab[tap_q]),
    .x_i      (x_hist_q[chan_q][tap_q]),
    .a_i      (a_tab[tap_q]),
    .y_i      (y_hist_q[chan_q][tap_q]),
`ifdef IIR_SAT_EN
    .clip_o   (mac_clip),
`endif
    .result_o (result)
  );

`ifdef IIR_SAT_EN
  // Only clips on written results count; partial sums are not outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                 sat_seen_q <= 1'b0;
    else if (wr_en && mac_clip) sat_seen_q <= 1'b1;
  end
  assign sat_seen = sat_seen_q;
`endif

  // The accumulator holds its final value throughout S_WRITE, so y_out is
  // stable across output stalls without a separate output register.
  assign x_in_rd_en  = rd_en;
  assign y_out_wr_en = wr_en;
  assign y_out       = result;
  assign ch_out      = chan_q;

endmodule
